// File: rtl/pdp8_pkg.sv
// Shared types and constants for the PDP8 memory arbiter.
// Word and address widths come from ADDR_WIDTH / DATA_WIDTH.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int STARVE_LIMIT_DFLT = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IFU,
        OWN_EXEC
    } owner_t;

    typedef enum logic [1:0] {
        ARB_RUN,
        ARB_DRAIN,
        ARB_HALTED
    } arb_state_t;

    function automatic owner_t owner_of(input logic g_ifu, input logic g_exec);
        owner_t o;
        o = OWN_NONE;
        if (g_ifu) begin
            o = OWN_IFU;
        end else if (g_exec) begin
            o = OWN_EXEC;
        end
        return o;
    endfunction

endpackage

// File: rtl/pdp8_arb_prio_sel.sv
// Priority select for the single memory port: one-hot grants.
// A starved IFU jumps the queue; otherwise write > read > fetch.
module pdp8_arb_prio_sel (
    input  logic en_i,
    input  logic ifu_req_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic starved_i,
    output logic ifu_gnt_o,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);

    // pick at most one requester this cycle
    always_comb begin
        ifu_gnt_o = 1'b0;
        rd_gnt_o  = 1'b0;
        wr_gnt_o  = 1'b0;
        if (!en_i) begin
            ifu_gnt_o = 1'b0;
        end else if (ifu_req_i && starved_i) begin
            ifu_gnt_o = 1'b1;
        end else if (wr_req_i) begin
            wr_gnt_o = 1'b1;
        end else if (rd_req_i) begin
            rd_gnt_o = 1'b1;
        end else if (ifu_req_i) begin
            ifu_gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port memory arbiter between IFU fetch and EXEC read/write.
// Registered command issue, 2-cycle read return tagged by owner.
module pdp8_mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rd_valid,
    output logic [DATA_W-1:0] ifu_rd_data,
    input  logic              exec_rd_req,
    input  logic [ADDR_W-1:0] exec_rd_addr,
    output logic              exec_rd_gnt,
    output logic              exec_rd_valid,
    output logic [DATA_W-1:0] exec_rd_data,
    input  logic              exec_wr_req,
    input  logic [ADDR_W-1:0] exec_wr_addr,
    input  logic [DATA_W-1:0] exec_wr_data,
    output logic              exec_wr_gnt,
    input  logic              halt,
    output logic              idle,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    owner_t            own1_q, own1_d;
    owner_t            own2_q, own2_d;
    logic              idle_q, idle_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic en;
    logic g_ifu;
    logic g_rd;
    logic g_wr;
    logic pipe_empty;

    assign en = (state_q == ARB_RUN) && !halt && !reset;
    assign pipe_empty = (own1_q == OWN_NONE) && (own2_q == OWN_NONE);

    pdp8_arb_prio_sel u_sel (
        .en_i      (en),
        .ifu_req_i (ifu_req),
        .rd_req_i  (exec_rd_req),
        .wr_req_i  (exec_wr_req),
        .starved_i (starve_q == LIM),
        .ifu_gnt_o (g_ifu),
        .rd_gnt_o  (g_rd),
        .wr_gnt_o  (g_wr)
    );

    assign ifu_gnt     = g_ifu;
    assign exec_rd_gnt = g_rd;
    assign exec_wr_gnt = g_wr;

    // next-state for starvation count, issue regs and owner pipe
    always_comb begin
        starve_d = starve_q;
        if (!ifu_req || g_ifu) begin
            starve_d = '0;
        end else if (starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
        end

        rd_req_d  = g_ifu || g_rd;
        rd_addr_d = rd_addr_q;
        if (g_ifu) begin
            rd_addr_d = ifu_addr;
        end else if (g_rd) begin
            rd_addr_d = exec_rd_addr;
        end

        wr_req_d  = g_wr;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (g_wr) begin
            wr_addr_d = exec_wr_addr;
            wr_data_d = exec_wr_data;
        end

        own1_d = owner_of(g_ifu, g_rd);
        own2_d = own1_q;
    end

    // run/drain/halted control and registered idle flag
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_RUN: begin
                if (halt) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!halt) state_d = ARB_RUN;
                else if (pipe_empty) state_d = ARB_HALTED;
            end
            ARB_HALTED: begin
                if (!halt) state_d = ARB_RUN;
            end
            default: state_d = ARB_RUN;
        endcase
        idle_d = (state_d == ARB_HALTED);
    end

    // state registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_RUN;
            starve_q  <= '0;
            own1_q    <= OWN_NONE;
            own2_q    <= OWN_NONE;
            idle_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            own1_q    <= own1_d;
            own2_q    <= own2_d;
            idle_q    <= idle_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_rd_req  = rd_req_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign idle        = idle_q;

    assign ifu_rd_valid  = (own2_q == OWN_IFU);
    assign exec_rd_valid = (own2_q == OWN_EXEC);
    assign ifu_rd_data   = ifu_rd_valid ? mem_rd_data : '0;
    assign exec_rd_data  = exec_rd_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Bench for pdp8_mem_arbiter: memory model, priority reference
// model and per-owner read scoreboards, directed plus random traffic.
module tb_pdp8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req;
    logic [11:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rd_valid;
    logic [11:0] ifu_rd_data;
    logic        exec_rd_req;
    logic [11:0] exec_rd_addr;
    logic        exec_rd_gnt;
    logic        exec_rd_valid;
    logic [11:0] exec_rd_data;
    logic        exec_wr_req;
    logic [11:0] exec_wr_addr;
    logic [11:0] exec_wr_data;
    logic        exec_wr_gnt;
    logic        halt;
    logic        idle;
    logic        mem_rd_req;
    logic [11:0] mem_rd_addr;
    logic [11:0] mem_rd_data;
    logic        mem_wr_req;
    logic [11:0] mem_wr_addr;
    logic [11:0] mem_wr_data;

    always #5 clk = ~clk;

    pdp8_mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .ifu_req       (ifu_req),
        .ifu_addr      (ifu_addr),
        .ifu_gnt       (ifu_gnt),
        .ifu_rd_valid  (ifu_rd_valid),
        .ifu_rd_data   (ifu_rd_data),
        .exec_rd_req   (exec_rd_req),
        .exec_rd_addr  (exec_rd_addr),
        .exec_rd_gnt   (exec_rd_gnt),
        .exec_rd_valid (exec_rd_valid),
        .exec_rd_data  (exec_rd_data),
        .exec_wr_req   (exec_wr_req),
        .exec_wr_addr  (exec_wr_addr),
        .exec_wr_data  (exec_wr_data),
        .exec_wr_gnt   (exec_wr_gnt),
        .halt          (halt),
        .idle          (idle),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data)
    );

    function automatic logic [11:0] init_word(input int i);
        logic [11:0] w;
        w = 12'(i * 37) ^ 12'h5A5;
        if (i == 16) w = 12'h7A1;
        return w;
    endfunction

    // synchronous single-port memory seen by the arbiter
    logic [11:0] mem [0:4095];
    logic [11:0] mem_q = 12'h000;
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            if (mem_wr_req) mem[mem_wr_addr] <= mem_wr_data;
            if (mem_rd_req) mem_q <= mem[mem_rd_addr];
        end
    end
    assign mem_rd_data = mem_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    exp_t        q_ifu[$];
    exp_t        q_exec[$];
    logic [11:0] ref_mem [0:4095];

    // monitor: reference priority model plus read scoreboards
    initial begin : monitor
        bit   halt_prev;
        int   starve_m;
        bit   e_i, e_r, e_w, run, exp_v;
        exp_t e;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        halt_prev = 1'b0;
        starve_m  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_ctrl", 64'({ifu_gnt, exec_rd_gnt, exec_wr_gnt,
                    ifu_rd_valid, exec_rd_valid, mem_rd_req, mem_wr_req,
                    idle}), 64'd0);
                chk("reset_regs", 64'({mem_rd_addr, mem_wr_addr,
                    mem_wr_data, ifu_rd_data, exec_rd_data}), 64'd0);
                q_ifu.delete();
                q_exec.delete();
                halt_prev = 1'b0;
                starve_m  = 0;
            end else begin
                exp_v = q_ifu.size() != 0 && q_ifu[0].due == cyc;
                if (ifu_rd_valid || exp_v)
                    chk("ifu_valid", 64'(ifu_rd_valid), 64'(exp_v));
                if (ifu_rd_valid && q_ifu.size() != 0) begin
                    e = q_ifu.pop_front();
                    chk("ifu_data", 64'(ifu_rd_data), 64'(e.data));
                    chk("ifu_latency", 64'(cyc), 64'(e.due));
                end else if (q_ifu.size() != 0 && q_ifu[0].due <= cyc) begin
                    e = q_ifu.pop_front();
                    if (e.due < cyc) chk("ifu_late", 64'(cyc), 64'(e.due));
                end

                exp_v = q_exec.size() != 0 && q_exec[0].due == cyc;
                if (exec_rd_valid || exp_v)
                    chk("exec_valid", 64'(exec_rd_valid), 64'(exp_v));
                if (exec_rd_valid && q_exec.size() != 0) begin
                    e = q_exec.pop_front();
                    chk("exec_data", 64'(exec_rd_data), 64'(e.data));
                    chk("exec_latency", 64'(cyc), 64'(e.due));
                end else if (q_exec.size() != 0 && q_exec[0].due <= cyc) begin
                    e = q_exec.pop_front();
                    if (e.due < cyc) chk("exec_late", 64'(cyc), 64'(e.due));
                end

                run = !halt && !halt_prev;
                e_i = 1'b0;
                e_r = 1'b0;
                e_w = 1'b0;
                if (run) begin
                    if (ifu_req && starve_m >= 4) e_i = 1'b1;
                    else if (exec_wr_req) e_w = 1'b1;
                    else if (exec_rd_req) e_r = 1'b1;
                    else if (ifu_req) e_i = 1'b1;
                end
                chk("grant", 64'({ifu_gnt, exec_rd_gnt, exec_wr_gnt}),
                    64'({e_i, e_r, e_w}));
                chk("mem_excl", 64'(mem_rd_req & mem_wr_req), 64'd0);

                if (exec_wr_req && exec_wr_gnt)
                    ref_mem[exec_wr_addr] = exec_wr_data;
                if (ifu_req && ifu_gnt)
                    q_ifu.push_back('{ref_mem[ifu_addr], cyc + 2});
                if (exec_rd_req && exec_rd_gnt)
                    q_exec.push_back('{ref_mem[exec_rd_addr], cyc + 2});

                if (ifu_req && !e_i) starve_m = (starve_m < 4) ? starve_m + 1 : 4;
                else starve_m = 0;
                halt_prev = halt;
            end
        end
    end

    bit gi, gr, gw, vi, id;

    task automatic tick();
        @(negedge clk);
        gi = ifu_req && ifu_gnt;
        gr = exec_rd_req && exec_rd_gnt;
        gw = exec_wr_req && exec_wr_gnt;
        vi = ifu_rd_valid || exec_rd_valid;
        id = idle;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] raddr();
        return ($urandom_range(7) == 0) ? 12'h200 : 12'($urandom_range(31));
    endfunction

    task automatic rand_phase(input int n, input int pi, input int pr,
                              input int pw, input int ph, input bit keep_rd);
        repeat (n) begin
            tick();
            if (!ifu_req || gi) begin
                ifu_req  = $urandom_range(99) < pi;
                ifu_addr = raddr();
            end
            if (!exec_rd_req || gr) begin
                exec_rd_req  = keep_rd || ($urandom_range(99) < pr);
                exec_rd_addr = raddr();
            end
            if (!exec_wr_req || gw) begin
                exec_wr_req  = $urandom_range(99) < pw;
                exec_wr_addr = raddr();
                exec_wr_data = 12'($urandom);
            end
            if ($urandom_range(99) < ph) halt = !halt;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int denied, nv, k;
        bit got, granted, seen;
        reset = 1'b1;
        ifu_req = 1'b0; ifu_addr = '0;
        exec_rd_req = 1'b0; exec_rd_addr = '0;
        exec_wr_req = 1'b0; exec_wr_addr = '0; exec_wr_data = '0;
        halt = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(idle), 64'd0);
        @(posedge clk);
        #1;

        // fetch alone: granted at once, data two cycles later
        ifu_req = 1'b1; ifu_addr = 12'h010;
        tick();
        chk("t1_gnt", 64'(gi), 64'd1);
        ifu_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t1_valid", 64'(ifu_rd_valid), 64'd1);
        chk("t1_data", 64'(ifu_rd_data), 64'h7A1);

        // write beats fetch, then read back the written word
        exec_wr_req = 1'b1; exec_wr_addr = 12'h200; exec_wr_data = 12'h123;
        ifu_req = 1'b1; ifu_addr = 12'h011;
        tick();
        chk("t2_wr_first", 64'({gi, gw}), 64'b01);
        exec_wr_req = 1'b0;
        tick();
        chk("t2_ifu_next", 64'(gi), 64'd1);
        ifu_req = 1'b0;
        exec_rd_req = 1'b1; exec_rd_addr = 12'h200;
        tick();
        chk("t2_rd_gnt", 64'(gr), 64'd1);
        exec_rd_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_rd_data", 64'(exec_rd_data), 64'h123);

        // write then read of the same word on the very next cycle
        tick();
        exec_wr_req = 1'b1; exec_wr_addr = 12'h201; exec_wr_data = 12'h456;
        tick();
        exec_wr_req = 1'b0;
        exec_rd_req = 1'b1; exec_rd_addr = 12'h201;
        tick();
        chk("t2b_rd_gnt", 64'(gr), 64'd1);
        exec_rd_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t2b_rd_data", 64'(exec_rd_data), 64'h456);
        repeat (2) tick();

        // continuous exec reads starve the fetch for exactly four cycles
        exec_rd_req = 1'b1; exec_rd_addr = 12'h005;
        ifu_req = 1'b1; ifu_addr = 12'h006;
        denied = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (gi) got = 1'b1;
            else denied++;
            exec_rd_addr = 12'(i + 6);
        end
        chk("t3_denied", 64'(denied), 64'd4);
        ifu_req = 1'b0;
        while (exec_rd_req && !gr) tick();
        exec_rd_req = 1'b0;
        repeat (3) tick();

        // alternating fetch / exec reads, one per cycle
        for (int i = 0; i < 8; i++) begin
            ifu_req = (i % 2 == 0);
            exec_rd_req = (i % 2 == 1);
            ifu_addr = raddr();
            exec_rd_addr = raddr();
            tick();
            chk("t4_gnt", 64'((i % 2 == 1) ? gr : gi), 64'd1);
        end
        ifu_req = 1'b0; exec_rd_req = 1'b0;
        repeat (3) tick();

        // halt with two reads in flight: drain, idle, then resume
        ifu_req = 1'b1; ifu_addr = 12'h007;
        tick();
        ifu_req = 1'b0;
        exec_rd_req = 1'b1; exec_rd_addr = 12'h008;
        tick();
        exec_rd_req = 1'b0;
        halt = 1'b1;
        ifu_req = 1'b1; ifu_addr = 12'h009;
        granted = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 12 && !seen; k++) begin
            tick();
            if (gi || gr || gw) granted = 1'b1;
            if (id) seen = 1'b1;
        end
        chk("t5_no_gnt", 64'(granted), 64'd0);
        chk("t5_idle", 64'(seen), 64'd1);
        chk("t5_drained", 64'(q_ifu.size() + q_exec.size()), 64'd0);
        halt = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (gi) got = 1'b1;
        end
        chk("t5_resume", 64'(got), 64'd1);
        ifu_req = 1'b0;
        repeat (3) tick();

        // reset during a read: outputs clear, no late valid
        ifu_req = 1'b1; ifu_addr = 12'h010;
        tick();
        ifu_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_outs", 64'({ifu_gnt, ifu_rd_valid, exec_rd_valid,
            mem_rd_req, mem_wr_req, idle, mem_rd_addr}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        nv = 0;
        repeat (6) begin
            tick();
            if (vi) nv++;
        end
        chk("t6_no_valid", 64'(nv), 64'd0);

        // random traffic, then starvation-heavy, then halt toggling
        rand_phase(2500, 50, 50, 30, 0, 1'b0);
        rand_phase(300, 70, 0, 0, 0, 1'b1);
        rand_phase(800, 50, 40, 30, 5, 1'b0);
        halt = 1'b0;
        rand_phase(30, 0, 0, 0, 0, 1'b0);
        repeat (4) tick();
        chk("final_drain", 64'(q_ifu.size() + q_exec.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
